// File: rtl/fma_dot_sequencer.sv
// fma_dot_sequencer: drives one fma lane through a single dot product.
// Takes a command (length N, bias c), forwards N operand pairs to the fma's packed {a, b, c}
// port with c_valid on the first issue and output_can_be_valid on the last, then captures the
// accumulated result and holds it until downstream accepts it.
//
// Ports
//   clk_in, rst_in                  clock (posedge), asynchronous active-low reset
//   cmd_valid_in/cmd_ready_out      command handshake; cmd_len_in = N, cmd_bias_in = initial c
//   op_valid_in/op_ready_out        operand handshake; op_a_in, op_b_in
//   abc_out, fma_valid_out,
//   fma_c_valid_out,
//   fma_out_can_be_valid_out        registered issue to the fma
//   fma_result_in, fma_valid_in     result returned by the fma
//   res_data_out/res_valid_out/
//   res_ready_in                    captured result, held until consumed
//   busy_out                        high whenever not idle
module fma_dot_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_LEN = 256,
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic [LEN_W-1:0]   cmd_len_in,
    input  logic [WIDTH-1:0]   cmd_bias_in,
    input  logic               op_valid_in,
    output logic               op_ready_out,
    input  logic [WIDTH-1:0]   op_a_in,
    input  logic [WIDTH-1:0]   op_b_in,
    output logic [3*WIDTH-1:0] abc_out,
    output logic               fma_valid_out,
    output logic               fma_c_valid_out,
    output logic               fma_out_can_be_valid_out,
    input  logic [WIDTH-1:0]   fma_result_in,
    input  logic               fma_valid_in,
    output logic [WIDTH-1:0]   res_data_out,
    output logic               res_valid_out,
    input  logic               res_ready_in,
    output logic               busy_out
);

    typedef enum logic [2:0] {StIdle, StRun, StZero, StWait, StHold} state_e;

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     bias_q, bias_d;
    logic [3*WIDTH-1:0]   abc_q, abc_d;
    logic                 valid_q, valid_d;
    logic                 c_valid_q, c_valid_d;
    logic                 ocbv_q, ocbv_d;
    logic [WIDTH-1:0]     res_q, res_d;

    logic [LEN_W-1:0]     len_sat;
    logic                 first_op;
    logic                 last_op;

    assign len_sat  = (cmd_len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_in;
    assign first_op = (cnt_q == '0);
    // len_q is never zero while in StRun, so len_q - 1 does not wrap there.
    assign last_op  = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        bias_d    = bias_q;
        res_d     = res_q;
        // Issue outputs default to idle so every issue is a single-cycle pulse.
        abc_d     = '0;
        valid_d   = 1'b0;
        c_valid_d = 1'b0;
        ocbv_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_in) begin
                    len_d   = len_sat;
                    bias_d  = cmd_bias_in;
                    cnt_d   = '0;
                    state_d = (len_sat == '0) ? StZero : StRun;
                end
            end
            StRun: begin
                if (op_valid_in) begin
                    abc_d     = {op_a_in, op_b_in, first_op ? bias_q : {WIDTH{1'b0}}};
                    valid_d   = 1'b1;
                    c_valid_d = first_op;
                    ocbv_d    = last_op;
                    cnt_d     = cnt_q + LEN_W'(1);
                    if (last_op) begin
                        state_d = StWait;
                    end
                end
            end
            StZero: begin
                // Empty dot product: 0*0 + bias still goes through the fma.
                abc_d     = {{WIDTH{1'b0}}, {WIDTH{1'b0}}, bias_q};
                valid_d   = 1'b1;
                c_valid_d = 1'b1;
                ocbv_d    = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                if (fma_valid_in) begin
                    res_d   = fma_result_in;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (res_ready_in) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            bias_q    <= '0;
            abc_q     <= '0;
            valid_q   <= 1'b0;
            c_valid_q <= 1'b0;
            ocbv_q    <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            bias_q    <= bias_d;
            abc_q     <= abc_d;
            valid_q   <= valid_d;
            c_valid_q <= c_valid_d;
            ocbv_q    <= ocbv_d;
            res_q     <= res_d;
        end
    end

    assign cmd_ready_out            = (state_q == StIdle);
    assign op_ready_out             = (state_q == StRun);
    assign res_valid_out            = (state_q == StHold);
    assign busy_out                 = (state_q != StIdle);
    assign abc_out                  = abc_q;
    assign fma_valid_out            = valid_q;
    assign fma_c_valid_out          = c_valid_q;
    assign fma_out_can_be_valid_out = ocbv_q;
    assign res_data_out             = res_q;

endmodule
